// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half adders; the only arithmetic in the block.
module serial_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic s0, c0, c1;

  serial_half_adder u_ha0 (.a_i(a_i), .b_i(b_i),   .sum_o(s0),    .carry_o(c0));
  serial_half_adder u_ha1 (.a_i(s0),  .b_i(cin_i), .sum_o(sum_o), .carry_o(c1));

  assign cout_o = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one full-adder cell over WIDTH cycles,
// LSB first, with a start/busy/done handshake and a held result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             cell_sum, cell_cout;

  serial_fa_cell u_cell (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .cin_i (carry_q),
    .sum_o (cell_sum),
    .cout_o(cell_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {cell_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        // Last bit: publish the fully assembled word on the same edge.
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_sh_d;
          cout_d  = cell_cout;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign sum_o   = sum_q;
  assign carry_o = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: timeline model compared every cycle, plus directed literal checks.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0, reset = 1'b0, start_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         busy_o, done_o, carry_o;
  logic [W-1:0] sum_o;
  logic         fa_a = 1'b0, fa_b = 1'b0, fa_c = 1'b0, fa_s, fa_co;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .carry_o(carry_o)
  );

  serial_fa_cell u_fa (.a_i(fa_a), .b_i(fa_b), .cin_i(fa_c), .sum_o(fa_s), .cout_o(fa_co));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: phase 0 = idle, 1..W = bit cycles, W+1 = result cycle.
  int           m_phase = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
  logic         m_cy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cy    <= 1'b0;
    end else if (m_phase == 0) begin
      if (start_i) begin
        m_phase <= 1;
        m_a     <= a_i;
        m_b     <= b_i;
      end
    end else if (m_phase == W) begin
      {m_cy, m_sum} <= {1'b0, m_a} + {1'b0, m_b};
      m_phase       <= W + 1;
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy",  64'(busy_o),  64'(m_phase != 0));
      chk("model_done",  64'(done_o),  64'(m_phase == W + 1));
      chk("model_sum",   64'(sum_o),   64'(m_sum));
      chk("model_carry", 64'(carry_o), 64'(m_cy));
    end
  end

  // Inputs change 2 time units after the falling edge, away from both sampling points.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, output logic [W:0] res);
    bit ok;
    tick();
    start_i = 1'b1; a_i = a; b_i = b;
    tick();
    start_i = 1'b0; a_i = W'($urandom); b_i = W'($urandom);
    ok = 1'b0; res = '0;
    for (int k = 0; k < W + 4 && !ok; k++) begin
      if (done_o) begin
        ok  = 1'b1;
        res = {carry_o, sum_o};
      end else tick();
    end
    chk("done_seen", 64'(ok), 64'(1));
    tick();
  endtask

  initial begin
    logic [W:0] r, first_r, last_r;
    logic [W:0] exp9;
    int ndone;

    #1 reset = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_busy",  64'(busy_o),  64'(0));
    chk("rst_done",  64'(done_o),  64'(0));
    chk("rst_sum",   64'(sum_o),   64'(0));
    chk("rst_carry", 64'(carry_o), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      {fa_a, fa_b, fa_c} = 3'(i);
      #1;
      chk("fa_cell", 64'({fa_co, fa_s}), 64'(int'(fa_a) + int'(fa_b) + int'(fa_c)));
    end

    // 0x5A + 0x33 with a cycle-exact busy/done profile.
    tick();
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h33;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start_i = 1'b0;
      chk($sformatf("t1_busy_k%0d", k), 64'(busy_o), 64'(k <= 9));
      chk($sformatf("t1_done_k%0d", k), 64'(done_o), 64'(k == 9));
      if (k == 9) begin
        chk("t1_sum",   64'(sum_o),   64'(8'h8D));
        chk("t1_carry", 64'(carry_o), 64'(0));
      end
    end

    do_add(8'hFF, 8'h01, r); chk("ff_01", 64'(r), 64'(9'h100));
    do_add(8'hFF, 8'hFF, r); chk("ff_ff", 64'(r), 64'(9'h1FE));

    // Abort mid-operation with reset.
    tick();
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h33;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("abort_busy",  64'(busy_o),  64'(0));
    chk("abort_done",  64'(done_o),  64'(0));
    chk("abort_sum",   64'(sum_o),   64'(0));
    chk("abort_carry", 64'(carry_o), 64'(0));
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_no_done", 64'(done_o), 64'(0));
    end
    do_add(8'h01, 8'h02, r); chk("after_abort", 64'(r), 64'(9'h003));

    // start held high, operands changing every cycle.
    tick();
    start_i = 1'b1;
    ndone = 0; first_r = '0; last_r = '0;
    for (int k = 1; k <= 50; k++) begin
      a_i = W'(k); b_i = W'(3 * k);
      tick();
      if (done_o) begin
        if (ndone == 0) first_r = {carry_o, sum_o};
        last_r = {carry_o, sum_o};
        ndone++;
      end
    end
    start_i = 1'b0;
    chk("held_count", 64'(ndone),   64'(5));
    chk("held_first", 64'(first_r), 64'(9'h004));
    chk("held_last",  64'(last_r),  64'(9'h0A4));
    tick(); tick();

    // Result held through the following add until its final edge.
    do_add(8'h10, 8'h20, r); chk("hold_first", 64'(r), 64'(9'h030));
    tick();
    start_i = 1'b1; a_i = 8'h80; b_i = 8'h80;
    for (int k = 1; k <= 9; k++) begin
      tick();
      start_i = 1'b0;
      chk($sformatf("hold_sum_k%0d", k),   64'(sum_o),   64'(k < 9 ? 8'h30 : 8'h00));
      chk($sformatf("hold_carry_k%0d", k), 64'(carry_o), 64'(k == 9));
    end
    tick(); tick();

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb};
      do_add(ra, rb, r);
      chk("rand_add", 64'(r), 64'(exp9));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
